minterm_scanner: RTL
====================

// Module: minterm_scanner
// PURPOSE
//  Sequential truth-table reader for N-input combinational functions (f(x,y,z) style blocks).
//  Drives every input combination 0..2^N-1 into the function under test and samples its single-bit output.
//  Assembles the sampled bits into a minterm mask and compares it against an expected mask.
//  Sits opposite the minterm-defined function blocks, replacing hand-written $monitor walks with a
//  self-checking, synthesizable scanner.
// PARAMETERS
//  N_VARS      3   number of function inputs; mask width is 2^N_VARS
//  SETTLE_CYC  1   cycles to hold each input vector before sampling (0 allowed)
// PORTS
//  clk       in   1         single clock; all state changes on rising edge
//  reset     in   1         synchronous, active-high reset
//  start     in   1         request a scan; accepted only in IDLE
//  expected  in   2^N       expected minterm mask; bit i = f(i); latched when start is accepted
//  fn_in     in   1         output of function under test
//  vars_out  out  N         input vector driven to function under test; MSB = x
//  busy      out  1         high from the cycle after start is accepted through the DONE cycle
//  done      out  1         one-cycle pulse; scan complete
//  mask      out  2^N       sampled minterm mask; held after done until next accepted start
//  match     out  1         mask == latched expected; valid with done, held until next start
// BEHAVIOUR
//  - Reset (any cycle, including mid-scan): state=IDLE; vars_out, mask, match, busy, done,
//    index and settle counter all 0. The latched expected value is also cleared.
//  - FSM states:
//    - IDLE -> SETTLE on start. If SETTLE_CYC == 0, IDLE -> SAMPLE directly.
//      On acceptance: index=0, mask=0, match=0, expected latched.
//    - SETTLE: vars_out=index; stay for SETTLE_CYC cycles, then go to SAMPLE.
//    - SAMPLE: mask[index] <= fn_in.
//      - If index == 2^N-1 -> DONE.
//      - Otherwise index++ and go to SETTLE (or SAMPLE again if SETTLE_CYC == 0).
//    - DONE: done=1 and match=(mask==expected) for one cycle, then -> IDLE.
//  - vars_out equals index in every non-IDLE state, so it is stable for SETTLE_CYC+1 cycles per vector.
//    It holds its last value (2^N-1) in IDLE after a scan.
//  - Latency: done is high exactly 2^N*(SETTLE_CYC+1)+1 cycles after the edge that accepted start.
//    Example: N_VARS=3, SETTLE_CYC=1 gives 17 cycles.
//  - start while busy (SETTLE/SAMPLE/DONE) is ignored; there is no queueing.
//    start in the same cycle as reset is ignored.
//  - Index wraps by design only through the terminal check; it is never incremented past 2^N-1.
//  - Changes to expected after acceptance have no effect on the current scan.
//  - Compare is a full-width equality; there are no don't-care bits.
// CONFIGURATION
//  MINTERM_SCANNER_ERRCNT_EN
//    - Defined: adds output err_cnt [N_VARS:0], the count of positions where mask[i] != expected[i].
//      It is computed incrementally at each SAMPLE, cleared at accepted start and on reset, and
//      valid with done.
//    - Undefined: the port and counter are absent; all other behaviour is identical.
// STRUCTURE
//  - Shared package minterm_scanner_pkg:
//    - state encoding (IDLE, SETTLE, SAMPLE, DONE)
//    - mask-width constant function (1 << N_VARS)
//    - counter-width helper for SETTLE_CYC
//  - One sub-module, settle_timer: loadable down-counter that asserts expire after SETTLE_CYC
//    cycles. It is bypassed when SETTLE_CYC == 0.
//  - The top level holds the FSM, index register, mask shift/insert, compare and optional err_cnt.
// TESTING
//  1. fn_in = (x&y)|(~x&~y&z), expected=8'b1100_0010, SETTLE_CYC=1
//     -> mask=8'hC2, match=1, done at cycle 17.
//  2. fn_in = y^z, expected=8'b0110_0110 with bit 0 flipped (8'h67)
//     -> mask=8'h66, match=0; with ERRCNT_EN, err_cnt=1.
//  3. fn_in tied 1, SETTLE_CYC=0 -> mask=8'hFF, done 9 cycles after the start edge,
//     vars_out steps 0..7 one per cycle.
//  4. Second start pulsed at cycle 5 of a running scan -> ignored; single done pulse at cycle 17;
//     mask is that of the first scan.
//  5. reset asserted at cycle 8 mid-scan -> next cycle all outputs 0, state IDLE;
//     a fresh start then completes normally with correct mask.
//  6. expected changed during a scan -> match reflects the value latched at start
//     (expected=8'hC2 latched, changed to 8'h00 -> match=1 for f1 stimulus).

Source files
------------

// File: rtl/minterm_scanner_pkg.sv
// rtl/minterm_scanner_pkg.sv - shared types and sizing helpers for the minterm scanner
// Purpose: scanner FSM state encoding, mask-width and settle-counter-width helpers.
// Ports: none (package).
package minterm_scanner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // One mask bit per input combination.
    function automatic int mask_width(input int n_vars);
        return 1 << n_vars;
    endfunction

    // The settle counter holds values 0..settle_cyc-1; keep at least one bit.
    function automatic int settle_cnt_width(input int settle_cyc);
        return (settle_cyc <= 2) ? 1 : $clog2(settle_cyc);
    endfunction

endpackage

// File: rtl/minterm_scanner_settle_timer.sv
// rtl/minterm_scanner_settle_timer.sv - loadable down-counter that times the settle phase
// Purpose: after load_i, expire_o rises once SETTLE_CYC cycles have elapsed (counting the
//          first cycle after the load edge as cycle one).
// Ports:
//   clk      in  clock
//   reset    in  synchronous active-high reset
//   load_i   in  restart the settle interval
//   expire_o out settle interval complete
module minterm_scanner_settle_timer
    import minterm_scanner_pkg::*;
#(
    parameter int SETTLE_CYC = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    output logic expire_o
);

    localparam int CW = settle_cnt_width(SETTLE_CYC);
    localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE_CYC - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Counts down to zero and rests there; it is only observed while settling.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/minterm_scanner.sv
// rtl/minterm_scanner.sv - sequential truth-table reader and minterm mask checker
// Purpose: walks vars_out through 0..2^N_VARS-1, samples fn_in per vector into mask,
//          and compares mask against the expected mask latched at start.
// Optional feature macro: MINTERM_SCANNER_ERRCNT_EN adds err_cnt (mismatching positions).
// Ports:
//   clk       in   clock
//   reset     in   synchronous active-high reset
//   start     in   scan request, accepted only when idle
//   expected  in   expected minterm mask (bit i = f(i)), latched on accepted start
//   fn_in     in   output of the function under test
//   vars_out  out  input vector to the function under test (MSB = x)
//   busy      out  scan in progress, through the done cycle
//   done      out  one-cycle completion pulse
//   mask      out  sampled minterm mask, held until next accepted start
//   match     out  mask equals latched expected, valid with done
//   err_cnt   out  (optional) count of mismatching mask positions
module minterm_scanner
    import minterm_scanner_pkg::*;
#(
    parameter int N_VARS     = 3,
    parameter int SETTLE_CYC = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [mask_width(N_VARS)-1:0]   expected,
    input  logic                            fn_in,
    output logic [N_VARS-1:0]               vars_out,
    output logic                            busy,
    output logic                            done,
    output logic [mask_width(N_VARS)-1:0]   mask,
    output logic                            match
`ifdef MINTERM_SCANNER_ERRCNT_EN
    ,
    output logic [N_VARS:0]                 err_cnt
`endif
);

    localparam int MW = mask_width(N_VARS);

    state_e            state_q, state_d;
    logic [N_VARS-1:0] index_q, index_d;
    logic [MW-1:0]     mask_q, mask_d;
    logic [MW-1:0]     exp_q, exp_d;
    logic              match_q, match_d;
    logic              done_q, done_d;
    logic              timer_load;
    logic              timer_expire;
`ifdef MINTERM_SCANNER_ERRCNT_EN
    logic [N_VARS:0]   err_q, err_d;
`endif

    generate
        if (SETTLE_CYC > 0) begin : g_timer
            minterm_scanner_settle_timer #(
                .SETTLE_CYC (SETTLE_CYC)
            ) u_settle_timer (
                .clk      (clk),
                .reset    (reset),
                .load_i   (timer_load),
                .expire_o (timer_expire)
            );
        end else begin : g_no_timer
            assign timer_expire = 1'b1;
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        mask_d     = mask_q;
        exp_d      = exp_q;
        match_d    = match_q;
        done_d     = 1'b0;
        timer_load = 1'b0;
`ifdef MINTERM_SCANNER_ERRCNT_EN
        err_d      = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    index_d = '0;
                    mask_d  = '0;
                    match_d = 1'b0;
                    exp_d   = expected;
`ifdef MINTERM_SCANNER_ERRCNT_EN
                    err_d   = '0;
`endif
                    if (SETTLE_CYC == 0) begin
                        state_d = ST_SAMPLE;
                    end else begin
                        state_d    = ST_SETTLE;
                        timer_load = 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                if (timer_expire) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                mask_d[index_q] = fn_in;
`ifdef MINTERM_SCANNER_ERRCNT_EN
                err_d = err_q + {{N_VARS{1'b0}}, fn_in ^ exp_q[index_q]};
`endif
                if (index_q == {N_VARS{1'b1}}) begin
                    state_d = ST_DONE;
                end else begin
                    index_d = index_q + 1'b1;
                    if (SETTLE_CYC == 0) begin
                        state_d = ST_SAMPLE;
                    end else begin
                        state_d    = ST_SETTLE;
                        timer_load = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                // done/match are registered here, so they appear the cycle after DONE.
                done_d  = 1'b1;
                match_d = (mask_q == exp_q);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            index_q <= '0;
            mask_q  <= '0;
            exp_q   <= '0;
            match_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef MINTERM_SCANNER_ERRCNT_EN
            err_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            mask_q  <= mask_d;
            exp_q   <= exp_d;
            match_q <= match_d;
            done_q  <= done_d;
`ifdef MINTERM_SCANNER_ERRCNT_EN
            err_q   <= err_d;
`endif
        end
    end

    // index is cleared on acceptance and never passes 2^N-1, so it doubles as vars_out
    // and naturally holds the last vector while idle.
    assign vars_out = index_q;
    assign busy     = (state_q != ST_IDLE) || done_q;
    assign done     = done_q;
    assign mask     = mask_q;
    assign match    = match_q;
`ifdef MINTERM_SCANNER_ERRCNT_EN
    assign err_cnt  = err_q;
`endif

endmodule
